// File: rtl/food_placer.sv
// Food placement for the snake game: draws random cells from the LFSR pair,
// checks each against the body occupancy, and falls back to a row-major scan.
//
// state  | meaning
// IDLE   | waiting for spawn_req
// SAMPLE | latch a random candidate, reject if off-grid
// QUERY  | present random candidate to occupancy logic
// CHECK  | occ_hit valid for the random candidate
// SCAN_Q | present scan pointer to occupancy logic
// SCAN_C | occ_hit valid for the scan pointer
module food_placer #(
    parameter int X_BITS    = 4,
    parameter int Y_BITS    = 4,
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 12,
    parameter int MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rand0,
    input  logic [7:0]        rand1,
    input  logic              spawn_req,
    input  logic              occ_hit,
    output logic [X_BITS-1:0] query_x,
    output logic [Y_BITS-1:0] query_y,
    output logic              query_valid,
    output logic [X_BITS-1:0] food_x,
    output logic [Y_BITS-1:0] food_y,
    output logic              food_valid,
    output logic              spawn_done,
    output logic              busy,
    output logic              board_full
);

    typedef enum logic [2:0] {
        IDLE, SAMPLE, QUERY, CHECK, SCAN_Q, SCAN_C
    } state_t;

    localparam logic [X_BITS:0]   GRID_W_EXT = (X_BITS+1)'(GRID_W);
    localparam logic [Y_BITS:0]   GRID_H_EXT = (Y_BITS+1)'(GRID_H);
    localparam logic [X_BITS-1:0] X_LAST     = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_LAST     = Y_BITS'(GRID_H - 1);
    localparam logic [7:0]        TRY_MAX    = 8'(MAX_TRIES);

    state_t            state, state_nxt;
    logic [7:0]        try_cnt, try_cnt_nxt, try_inc;
    logic [X_BITS-1:0] query_x_nxt, food_x_nxt, cand_x;
    logic [Y_BITS-1:0] query_y_nxt, food_y_nxt, cand_y;
    logic              food_valid_nxt, spawn_done_nxt, board_full_nxt;
    logic              cand_ok, accept;
    logic              unused_rand;

    assign cand_x      = rand0[X_BITS-1:0];
    assign cand_y      = rand1[Y_BITS-1:0];
    assign cand_ok     = ({1'b0, cand_x} < GRID_W_EXT) && ({1'b0, cand_y} < GRID_H_EXT);
    assign try_inc     = try_cnt + 8'd1;
    assign unused_rand = ^{rand0, rand1};

    assign query_valid = (state == QUERY) || (state == SCAN_Q);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        try_cnt_nxt    = try_cnt;
        query_x_nxt    = query_x;
        query_y_nxt    = query_y;
        food_x_nxt     = food_x;
        food_y_nxt     = food_y;
        food_valid_nxt = food_valid;
        board_full_nxt = board_full;
        spawn_done_nxt = 1'b0;
        accept         = 1'b0;

        case (state)
            IDLE: begin
                if (spawn_req) begin
                    state_nxt      = SAMPLE;
                    food_valid_nxt = 1'b0;
                    board_full_nxt = 1'b0;
                    try_cnt_nxt    = 8'd0;
                end
            end
            SAMPLE: begin
                query_x_nxt = cand_x;
                query_y_nxt = cand_y;
                try_cnt_nxt = try_inc;
                if (cand_ok) begin
                    state_nxt = QUERY;
                end else if (try_inc >= TRY_MAX) begin
                    state_nxt   = SCAN_Q;
                    query_x_nxt = '0;
                    query_y_nxt = '0;
                end
            end
            QUERY: state_nxt = CHECK;
            CHECK: begin
                if (!occ_hit) begin
                    accept = 1'b1;
                end else if (try_cnt < TRY_MAX) begin
                    state_nxt = SAMPLE;
                end else begin
                    state_nxt   = SCAN_Q;
                    query_x_nxt = '0;
                    query_y_nxt = '0;
                end
            end
            SCAN_Q: state_nxt = SCAN_C;
            SCAN_C: begin
                if (!occ_hit) begin
                    accept = 1'b1;
                end else if (query_x == X_LAST && query_y == Y_LAST) begin
                    board_full_nxt = 1'b1;
                    spawn_done_nxt = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    // the scan pointer lives in query_x/query_y
                    state_nxt = SCAN_Q;
                    if (query_x == X_LAST) begin
                        query_x_nxt = '0;
                        query_y_nxt = query_y + Y_BITS'(1);
                    end else begin
                        query_x_nxt = query_x + X_BITS'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (accept) begin
            food_x_nxt     = query_x;
            food_y_nxt     = query_y;
            food_valid_nxt = 1'b1;
            spawn_done_nxt = 1'b1;
            state_nxt      = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            try_cnt    <= 8'd0;
            query_x    <= '0;
            query_y    <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            spawn_done <= 1'b0;
            board_full <= 1'b0;
        end else begin
            state      <= state_nxt;
            try_cnt    <= try_cnt_nxt;
            query_x    <= query_x_nxt;
            query_y    <= query_y_nxt;
            food_x     <= food_x_nxt;
            food_y     <= food_y_nxt;
            food_valid <= food_valid_nxt;
            spawn_done <= spawn_done_nxt;
            board_full <= board_full_nxt;
        end
    end

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer: a latency-rule model predicts queries and
// the spawn outcome, and a compare process checks outputs every cycle.
module tb_food_placer;

    localparam int GW   = 16;
    localparam int GH   = 12;
    localparam int MT   = 8;
    localparam int TLEN = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rand0, rand1;
    logic       spawn_req, occ_hit;
    logic [3:0] query_x, food_x;
    logic [3:0] query_y, food_y;
    logic       query_valid, food_valid, spawn_done, busy, board_full;

    food_placer #(
        .X_BITS(4), .Y_BITS(4), .GRID_W(GW), .GRID_H(GH), .MAX_TRIES(MT)
    ) dut (
        .clk(clk), .rst(rst), .rand0(rand0), .rand1(rand1),
        .spawn_req(spawn_req), .occ_hit(occ_hit),
        .query_x(query_x), .query_y(query_y), .query_valid(query_valid),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .spawn_done(spawn_done), .busy(busy), .board_full(board_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit [7:0] r0tab[TLEN];
    bit [7:0] r1tab[TLEN];
    bit       occ[16][16];

    bit exp_qv[TLEN];
    int exp_qx[TLEN];
    int exp_qy[TLEN];
    int done, efx, efy, nq;
    bit efull;

    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Cycle k counts from the edge where spawn_req is taken (k=0: first SAMPLE cycle).
    task automatic build_model();
        int t, tries, px, py, cx, cy;
        bit scanning, fin;
        t = 0; tries = 0; px = 0; py = 0; scanning = 0; fin = 0;
        nq = 0; efull = 0; efx = 0; efy = 0; done = TLEN - 4;
        for (int i = 0; i < TLEN; i++) begin
            exp_qv[i] = 0; exp_qx[i] = 0; exp_qy[i] = 0;
        end
        while (!fin && t < TLEN - 4) begin
            if (!scanning) begin
                cx = int'(r0tab[t]) % 16;
                cy = int'(r1tab[t]) % 16;
                tries++;
                if (cx >= GW || cy >= GH) begin
                    t += 1;
                    if (tries >= MT) scanning = 1;
                end else begin
                    exp_qv[t+1] = 1; exp_qx[t+1] = cx; exp_qy[t+1] = cy; nq++;
                    if (!occ[cx][cy]) begin
                        done = t + 3; efx = cx; efy = cy; fin = 1;
                    end else begin
                        t += 3;
                        if (tries >= MT) scanning = 1;
                    end
                end
            end else begin
                exp_qv[t] = 1; exp_qx[t] = px; exp_qy[t] = py; nq++;
                if (!occ[px][py]) begin
                    done = t + 2; efx = px; efy = py; fin = 1;
                end else if (px == GW - 1 && py == GH - 1) begin
                    done = t + 2; efull = 1; fin = 1;
                end else begin
                    t += 2; px++;
                    if (px == GW) begin px = 0; py++; end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en && cyc >= 0 && cyc < TLEN) begin
            chk("query_valid", query_valid, exp_qv[cyc]);
            if (exp_qv[cyc] && query_valid) begin
                chk("query_x", query_x, exp_qx[cyc]);
                chk("query_y", query_y, exp_qy[cyc]);
            end
            chk("busy", busy, cyc < done);
            chk("spawn_done", spawn_done, cyc == done);
            chk("food_valid", food_valid, (cyc >= done) && !efull);
            chk("board_full", board_full, (cyc >= done) && efull);
            if (cyc >= done && !efull) begin
                chk("food_x", food_x, efx);
                chk("food_y", food_y, efy);
            end
        end
    end

    task automatic fill_rand(input bit [7:0] a, input bit [7:0] b);
        for (int i = 0; i < TLEN; i++) begin
            r0tab[i] = a; r1tab[i] = b;
        end
    endtask

    task automatic fill_occ(input bit v);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                occ[x][y] = v;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_qv"}, query_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fv"}, food_valid, 0);
        chk({tag, "_sd"}, spawn_done, 0);
        chk({tag, "_bf"}, board_full, 0);
        chk({tag, "_fx"}, food_x, 0);
        chk({tag, "_fy"}, food_y, 0);
        chk({tag, "_qx"}, query_x, 0);
        chk({tag, "_qy"}, query_y, 0);
    endtask

    // extra_at: cycle for a spurious spawn_req while busy; abort_at: cycle to drop rst
    task automatic run_spawn(input int extra_at, input int abort_at);
        bit pq;
        int pqx, pqy;
        pq = 0; pqx = 0; pqy = 0;
        build_model();
        @(negedge clk);
        spawn_req = 1'b1; rand0 = r0tab[0]; rand1 = r1tab[0]; occ_hit = 1'b0;
        @(posedge clk);
        cyc = 0; chk_en = 1'b1;
        for (int k = 0; k <= done + 2; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                chk_en = 1'b0;
                #1 rst = 1'b0;
                #1 check_all_zero("rst_async");
                spawn_req = 1'b0; occ_hit = 1'b0;
                break;
            end
            spawn_req = (k == extra_at);
            rand0 = r0tab[k]; rand1 = r1tab[k];
            occ_hit = pq ? occ[pqx][pqy] : 1'b0;
            pq = query_valid; pqx = int'(query_x); pqy = int'(query_y);
            @(posedge clk);
            cyc = k + 1;
        end
        chk_en = 1'b0;
        spawn_req = 1'b0; occ_hit = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rand0 = 8'h00; rand1 = 8'h00; spawn_req = 1'b0; occ_hit = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // best case
        fill_occ(0); fill_rand(8'h05, 8'h03);
        run_spawn(-1, -1);
        chk("t1_model_done", done, 3);
        chk("t1_food_x", food_x, 5);
        chk("t1_food_y", food_y, 3);
        chk("t1_busy", busy, 0);

        // one off-grid draw (y=12)
        fill_occ(0); fill_rand(8'h02, 8'h07); r1tab[0] = 8'h0C;
        run_spawn(-1, -1);
        chk("t2_model_done", done, 4);
        chk("t2_food_y", food_y, 7);

        // two occupied draws, spurious spawn_req while busy
        fill_occ(0); occ[1][1] = 1; occ[2][2] = 1;
        for (int i = 0; i < TLEN; i++) begin
            r0tab[i] = (i < 3) ? 8'h01 : (i < 6) ? 8'h02 : 8'h03;
            r1tab[i] = r0tab[i];
        end
        run_spawn(4, -1);
        chk("t3_model_done", done, 9);
        chk("t3_model_nq", nq, 3);
        chk("t3_food_x", food_x, 3);

        // all random tries fail, scan finds (2,0)
        fill_occ(0); occ[5][5] = 1; occ[0][0] = 1; occ[1][0] = 1;
        fill_rand(8'h55, 8'h25);
        run_spawn(-1, -1);
        chk("t4_model_done", done, 30);
        chk("t4_food_x", food_x, 2);
        chk("t4_food_y", food_y, 0);

        // full board
        fill_occ(1); fill_rand(8'h05, 8'h05);
        run_spawn(10, -1);
        chk("t5_model_done", done, 408);
        chk("t5_board_full", board_full, 1);
        chk("t5_food_valid", food_valid, 0);

        // next spawn clears board_full
        fill_occ(1); occ[3][3] = 0; fill_rand(8'h33, 8'h33);
        run_spawn(-1, -1);
        chk("t6_board_full", board_full, 0);
        chk("t6_food_valid", food_valid, 1);

        // async reset during CHECK, then normal spawn at the far corner
        fill_occ(0); fill_rand(8'h0A, 8'h04);
        run_spawn(-1, 2);
        @(negedge clk);
        check_all_zero("rst_hold");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fill_occ(0); fill_rand(8'hFF, 8'h0B);
        run_spawn(-1, -1);
        chk("t8_food_x", food_x, 15);
        chk("t8_food_y", food_y, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
